// File: rtl/hft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hft_pkg
// Description : Shared constants and types for the bid-side order book:
//               message type codes, message field offsets, book entry
//               layout and per-slot update selects.
// Revision    : 1.0  initial release
// ============================================================================
package hft_pkg;

   // Message type codes carried in the top byte of the message
   localparam logic [7:0] MSG_ADD = 8'h53;   // 'S'
   localparam logic [7:0] MSG_DEL = 8'h44;   // 'D'
   localparam logic [7:0] MSG_EXE = 8'h45;   // 'E'

   // Field LSB positions inside the 320-bit message
   localparam int TYPE_LSB  = 312;
   localparam int ID_LSB    = 216;
   localparam int QTY_LSB   = 96;
   localparam int PRICE_LSB = 32;

   typedef struct packed {
      logic        valid;
      logic [31:0] id;
      logic [31:0] qty;
      logic [63:0] price;
   } book_entry_t;

   // Per-slot update select: keep, load a new value, take the entry from
   // the slot above (shift down) or from the slot below (shift up).
   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_LOAD = 2'd1,
      SEL_DOWN = 2'd2,
      SEL_UP   = 2'd3
   } slot_sel_t;

endpackage : hft_pkg
`default_nettype wire

// File: rtl/bid_book_slot.sv
`default_nettype none
// ============================================================================
// Module      : bid_book_slot
// Description : One book entry register. Updated from a load value or
//               from a neighbouring slot; reports whether its price is
//               >= the message price and whether its id matches.
// Revision    : 1.0  initial release
// ============================================================================
module bid_book_slot
   import hft_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  slot_sel_t   i_sel,
   input  book_entry_t i_load,
   input  book_entry_t i_prev,
   input  book_entry_t i_next,
   input  logic [63:0] i_price,
   input  logic [31:0] i_id,
   output book_entry_t o_entry,
   output logic        o_ge,
   output logic        o_match
);

   book_entry_t r_entry;
   book_entry_t w_next;

   // Select the next content of this slot
   always_comb begin
      w_next = r_entry;
      case (i_sel)
         SEL_LOAD: w_next = i_load;
         SEL_DOWN: w_next = i_prev;
         SEL_UP:   w_next = i_next;
         default:  w_next = r_entry;
      endcase
   end

   // Entry storage; cleared to an invalid, all-zero entry on reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_entry <= '0;
      else         r_entry <= w_next;
   end

   assign o_entry = r_entry;
   assign o_ge    = r_entry.valid && (r_entry.price >= i_price);
   assign o_match = r_entry.valid && (r_entry.id == i_id);

endmodule : bid_book_slot
`default_nettype wire

// File: rtl/bid_book_top4.sv
`default_nettype none
// ============================================================================
// Module      : bid_book_top4
// Description : Bid-side limit order book. Accepts add/delete/execute
//               messages through an IDLE -> CALC -> WRITE handshake and
//               presents the four best (highest price) resting bids.
// Revision    : 1.0  initial release
// ============================================================================
module bid_book_top4
   import hft_pkg::*;
#(
   parameter int DEPTH = 8    // must be >= 4; slots beyond rank 4 are hidden
)(
   input  logic         clk,
   input  logic         resetn,
   input  logic         buffer_not_empty,
   input  logic [319:0] ff_buffer,
   output logic         system_free,
   output logic [31:0]  max_order_id_1,
   output logic [31:0]  max_quantity_1,
   output logic [63:0]  max_price_1,
   output logic [31:0]  max_order_id_2,
   output logic [31:0]  max_quantity_2,
   output logic [63:0]  max_price_2,
   output logic [31:0]  max_order_id_3,
   output logic [31:0]  max_quantity_3,
   output logic [63:0]  max_price_3,
   output logic [31:0]  max_order_id_4,
   output logic [31:0]  max_quantity_4,
   output logic [63:0]  max_price_4
);

   // Index width able to represent DEPTH itself ("insert past the end")
   localparam int IW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_free;
   logic [7:0]    r_type;
   logic [31:0]   r_id;
   logic [31:0]   r_qty;
   logic [63:0]   r_price;
   logic [IW-1:0] r_ins_pos;
   logic          r_hit;
   logic [IW-1:0] r_hit_idx;
   logic [31:0]   r_hit_qty;
   logic [63:0]   r_hit_price;

   book_entry_t   w_entry [DEPTH];
   book_entry_t   w_ext   [DEPTH+2];   // entries padded with empty neighbours
   slot_sel_t     w_sel   [DEPTH];
   book_entry_t   w_load;
   logic [DEPTH-1:0] w_ge;
   logic [DEPTH-1:0] w_match;
   logic [IW-1:0] w_ins_pos;
   logic          w_hit;
   logic [IW-1:0] w_hit_idx;
   logic [31:0]   w_hit_qty;
   logic [63:0]   w_hit_price;
   logic          w_unused_bits;

   // Message bits outside the decoded fields carry nothing for this book
   assign w_unused_bits = ^{ff_buffer[311:248], ff_buffer[215:128], ff_buffer[31:0]};

   assign w_ext[0]       = '0;
   assign w_ext[DEPTH+1] = '0;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_ext[gi+1] = w_entry[gi];
      bid_book_slot u_slot (
         .clk     (clk),
         .resetn  (resetn),
         .i_sel   (w_sel[gi]),
         .i_load  (w_load),
         .i_prev  (w_ext[gi]),
         .i_next  (w_ext[gi+2]),
         .i_price (r_price),
         .i_id    (r_id),
         .o_entry (w_entry[gi]),
         .o_ge    (w_ge[gi]),
         .o_match (w_match[gi])
      );
   end

   // Insertion point is the count of entries priced >= the new price (book is
   // sorted, so they form a prefix); the match is the first id hit from the top
   always_comb begin
      w_ins_pos   = '0;
      w_hit       = 1'b0;
      w_hit_idx   = '0;
      w_hit_qty   = '0;
      w_hit_price = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_ge[i]) w_ins_pos = w_ins_pos + IW'(1);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_hit       = 1'b1;
            w_hit_idx   = IW'(i);
            w_hit_qty   = w_entry[i].qty;
            w_hit_price = w_entry[i].price;
         end
      end
   end

   // Per-slot update selects, active only in WRITE
   always_comb begin
      w_load = '0;
      for (int i = 0; i < DEPTH; i++) w_sel[i] = SEL_HOLD;
      if (r_state == ST_WRITE) begin
         case (r_type)
            MSG_ADD: begin
               w_load = '{valid: 1'b1, id: r_id, qty: r_qty, price: r_price};
               // Insert position == DEPTH means full book and not better than the tail
               if (r_ins_pos != IW'(DEPTH)) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (IW'(i) == r_ins_pos)     w_sel[i] = SEL_LOAD;
                     else if (IW'(i) > r_ins_pos) w_sel[i] = SEL_DOWN;
                  end
               end
            end
            MSG_DEL: begin
               if (r_hit) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (IW'(i) >= r_hit_idx) w_sel[i] = SEL_UP;
                  end
               end
            end
            MSG_EXE: begin
               if (r_hit) begin
                  if (r_qty >= r_hit_qty) begin
                     for (int i = 0; i < DEPTH; i++) begin
                        if (IW'(i) >= r_hit_idx) w_sel[i] = SEL_UP;
                     end
                  end else begin
                     w_load = '{valid: 1'b1, id: r_id, qty: r_hit_qty - r_qty,
                                price: r_hit_price};
                     for (int i = 0; i < DEPTH; i++) begin
                        if (IW'(i) == r_hit_idx) w_sel[i] = SEL_LOAD;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake FSM: latch the message, register the compare results, commit
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_free      <= 1'b1;
         r_type      <= '0;
         r_id        <= '0;
         r_qty       <= '0;
         r_price     <= '0;
         r_ins_pos   <= '0;
         r_hit       <= 1'b0;
         r_hit_idx   <= '0;
         r_hit_qty   <= '0;
         r_hit_price <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (buffer_not_empty) begin
                  r_type  <= ff_buffer[TYPE_LSB  +: 8];
                  r_id    <= ff_buffer[ID_LSB    +: 32];
                  r_qty   <= ff_buffer[QTY_LSB   +: 32];
                  r_price <= ff_buffer[PRICE_LSB +: 64];
                  r_free  <= 1'b0;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_ins_pos   <= w_ins_pos;
               r_hit       <= w_hit;
               r_hit_idx   <= w_hit_idx;
               r_hit_qty   <= w_hit_qty;
               r_hit_price <= w_hit_price;
               r_state     <= ST_WRITE;
            end
            ST_WRITE: begin
               r_free  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_free  <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign system_free = r_free;

   // Ranks come straight from the slot registers, which only change in WRITE
   // or on reset; invalid slots read as zero
   assign max_order_id_1 = w_entry[0].valid ? w_entry[0].id    : '0;
   assign max_quantity_1 = w_entry[0].valid ? w_entry[0].qty   : '0;
   assign max_price_1    = w_entry[0].valid ? w_entry[0].price : '0;
   assign max_order_id_2 = w_entry[1].valid ? w_entry[1].id    : '0;
   assign max_quantity_2 = w_entry[1].valid ? w_entry[1].qty   : '0;
   assign max_price_2    = w_entry[1].valid ? w_entry[1].price : '0;
   assign max_order_id_3 = w_entry[2].valid ? w_entry[2].id    : '0;
   assign max_quantity_3 = w_entry[2].valid ? w_entry[2].qty   : '0;
   assign max_price_3    = w_entry[2].valid ? w_entry[2].price : '0;
   assign max_order_id_4 = w_entry[3].valid ? w_entry[3].id    : '0;
   assign max_quantity_4 = w_entry[3].valid ? w_entry[3].qty   : '0;
   assign max_price_4    = w_entry[3].valid ? w_entry[3].price : '0;

endmodule : bid_book_top4
`default_nettype wire

// File: tb/tb_bid_book_top4.sv
`default_nettype none
// ============================================================================
// Module      : tb_bid_book_top4
// Description : Self-checking bench for bid_book_top4 against a queue-based
//               order book model (sorted list, insert/remove by rule).
// Revision    : 1.0  initial release
// ============================================================================
module tb_bid_book_top4;
   import hft_pkg::*;

   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         buffer_not_empty = 1'b0;
   logic [319:0] ff_buffer = '0;
   logic         system_free;
   logic [31:0]  max_order_id_1, max_quantity_1, max_order_id_2, max_quantity_2;
   logic [31:0]  max_order_id_3, max_quantity_3, max_order_id_4, max_quantity_4;
   logic [63:0]  max_price_1, max_price_2, max_price_3, max_price_4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] id;
      logic [31:0] qty;
      logic [63:0] price;
   } ref_t;
   ref_t book[$];

   bid_book_top4 #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .buffer_not_empty(buffer_not_empty),
      .ff_buffer(ff_buffer), .system_free(system_free),
      .max_order_id_1(max_order_id_1), .max_quantity_1(max_quantity_1), .max_price_1(max_price_1),
      .max_order_id_2(max_order_id_2), .max_quantity_2(max_quantity_2), .max_price_2(max_price_2),
      .max_order_id_3(max_order_id_3), .max_quantity_3(max_quantity_3), .max_price_3(max_price_3),
      .max_order_id_4(max_order_id_4), .max_quantity_4(max_quantity_4), .max_price_4(max_price_4)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [127:0] exp_rank(int r);
      if (r <= book.size()) return {book[r-1].id, book[r-1].qty, book[r-1].price};
      return '0;
   endfunction

   function automatic logic [127:0] dut_rank(int r);
      case (r)
         1: return {max_order_id_1, max_quantity_1, max_price_1};
         2: return {max_order_id_2, max_quantity_2, max_price_2};
         3: return {max_order_id_3, max_quantity_3, max_price_3};
         default: return {max_order_id_4, max_quantity_4, max_price_4};
      endcase
   endfunction

   task automatic model_apply(logic [7:0] t, logic [31:0] id, logic [31:0] qty, logic [63:0] price);
      int pos;
      int hit;
      ref_t e;
      if (t == MSG_ADD) begin
         pos = 0;
         foreach (book[i]) if (book[i].price >= price) pos++;
         if (book.size() == DEPTH && pos == DEPTH) return;
         e.id = id; e.qty = qty; e.price = price;
         book.insert(pos, e);
         if (book.size() > DEPTH) void'(book.pop_back());
      end else if (t == MSG_DEL || t == MSG_EXE) begin
         hit = -1;
         foreach (book[i]) if (hit < 0 && book[i].id == id) hit = i;
         if (hit < 0) return;
         if (t == MSG_DEL || qty >= book[hit].qty) book.delete(hit);
         else book[hit].qty = book[hit].qty - qty;
      end
   endtask

   // ---------------- stimulus ----------------
   function automatic logic [319:0] mk_msg(logic [7:0] t, logic [31:0] id, logic [31:0] qty, logic [63:0] price);
      logic [319:0] m;
      for (int w = 0; w < 10; w++) m[w*32 +: 32] = $urandom();
      m[319:312] = t;
      m[247:216] = id;
      m[127:96]  = qty;
      m[95:32]   = price;
      return m;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b0;
      buffer_not_empty = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      book.delete();
   endtask

   // Sends one message; lat = edges after the accept edge until system_free rises
   task automatic send(logic [7:0] t, logic [31:0] id, logic [31:0] qty, logic [63:0] price, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!system_free && n < 50) begin @(negedge clk); n++; end
      ff_buffer = mk_msg(t, id, qty, price);
      buffer_not_empty = 1'b1;
      @(posedge clk);
      #1;
      buffer_not_empty = 1'b0;
      ff_buffer = {10{$urandom()}};
      lat = 0;
      while (lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
         if (system_free) break;
      end
      model_apply(t, id, qty, price);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if (system_free !== 1'b1) begin $display("FAIL reset_free: got %b expected 1", system_free); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== 128'h0) begin $display("FAIL reset_rank%0d: got %h expected 0", r, dut_rank(r)); errors++; end
      end
   endtask

   task automatic test_single_add();
      int lat;
      send(MSG_ADD, 32'h000103EB, 32'h00640001, 64'h550601, lat);
      checks++;
      if (lat !== 2) begin $display("FAIL single_add_latency: got %0d expected 2", lat); errors++; end
      checks++;
      if ({max_order_id_1, max_quantity_1, max_price_1} !== {32'h000103EB, 32'h00640001, 64'h550601}) begin
         $display("FAIL single_add_rank1: got %h %h %h expected 000103eb 00640001 550601",
                  max_order_id_1, max_quantity_1, max_price_1);
         errors++;
      end
      for (int r = 2; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== 128'h0) begin $display("FAIL single_add_rank%0d: got %h expected 0", r, dut_rank(r)); errors++; end
      end
   endtask

   task automatic test_increasing();
      int lat;
      apply_reset();
      for (int i = 0; i < 5; i++) send(MSG_ADD, 32'h100 + i, 32'h10 + i, 64'h1000 + i, lat);
      checks++;
      if (max_order_id_1 !== 32'h104 || max_order_id_4 !== 32'h101) begin
         $display("FAIL increasing_ids: got rank1=%h rank4=%h expected 104 101", max_order_id_1, max_order_id_4);
         errors++;
      end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL increasing_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_delete();
      int lat;
      send(MSG_DEL, book[0].id, 32'h0, 64'h0, lat);
      checks++;
      if (max_order_id_4 !== 32'h100) begin $display("FAIL delete_hidden_rank5: got %h expected 100", max_order_id_4); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL delete_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
      send(MSG_DEL, 32'h000103FF, 32'h0, 64'h0, lat);
      checks++;
      if (lat !== 2) begin $display("FAIL delete_absent_latency: got %0d expected 2", lat); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL delete_absent_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_execute();
      int lat;
      logic [31:0] q;
      send(MSG_EXE, book[1].id, book[1].qty, 64'h0, lat);
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL exec_full_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
      q = book[1].qty;
      send(MSG_EXE, book[1].id, 32'h3, 64'h0, lat);
      checks++;
      if (max_quantity_2 !== q - 32'h3) begin $display("FAIL exec_partial_qty: got %h expected %h", max_quantity_2, q - 32'h3); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL exec_partial_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_equal_price();
      int lat;
      send(MSG_ADD, 32'hABC, 32'h77, book[0].price, lat);
      checks++;
      if (max_order_id_2 !== 32'hABC) begin $display("FAIL equal_price_rank2: got %h expected abc", max_order_id_2); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL equal_price_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_full_drop();
      int lat;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) send(MSG_ADD, 32'h200 + i, 32'h5, 64'd100 + i, lat);
      send(MSG_ADD, 32'h2F0, 32'h5, 64'd50, lat);    // below minimum
      send(MSG_ADD, 32'h2F1, 32'h5, 64'd100, lat);   // equal to minimum
      for (int i = DEPTH - 1; i >= 1; i--) send(MSG_DEL, 32'h200 + i, 32'h0, 64'h0, lat);
      checks++;
      if (max_order_id_1 !== 32'h200 || max_order_id_2 !== 32'h0) begin
         $display("FAIL full_drop_survivor: got rank1=%h rank2=%h expected 200 0", max_order_id_1, max_order_id_2);
         errors++;
      end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL full_drop_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      send(MSG_ADD, 32'h300, 32'h9, 64'h900, lat);
      @(negedge clk);
      ff_buffer = mk_msg(MSG_ADD, 32'h301, 32'h9, 64'h901);
      buffer_not_empty = 1'b1;
      @(posedge clk);
      #1;
      buffer_not_empty = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (system_free !== 1'b1) begin $display("FAIL reset_mid_free: got %b expected 1", system_free); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== 128'h0) begin $display("FAIL reset_mid_rank%0d: got %h expected 0", r, dut_rank(r)); errors++; end
      end
      book.delete();
      @(negedge clk);
      resetn = 1'b1;
      send(MSG_ADD, 32'h302, 32'h4, 64'h44, lat);
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL reset_mid_after_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_other_type();
      int lat;
      send(MSG_ADD, 32'h400, 32'h8, 64'h10, lat);
      send(8'h41, 32'h400, 32'h8, 64'h99, lat);
      checks++;
      if (lat !== 2) begin $display("FAIL other_type_latency: got %0d expected 2", lat); errors++; end
      for (int r = 1; r <= 4; r++) begin
         checks++;
         if (dut_rank(r) !== exp_rank(r)) begin $display("FAIL other_type_rank%0d: got %h expected %h", r, dut_rank(r), exp_rank(r)); errors++; end
      end
   endtask

   task automatic test_random();
      int lat;
      int sel;
      logic [7:0]  t;
      logic [31:0] id;
      apply_reset();
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 99);
         if (sel < 45)      t = MSG_ADD;
         else if (sel < 65) t = MSG_DEL;
         else if (sel < 90) t = MSG_EXE;
         else               t = 8'h20;
         if (t != MSG_ADD && book.size() > 0 && $urandom_range(0, 3) != 0)
            id = book[$urandom_range(0, book.size() - 1)].id;
         else
            id = 32'($urandom_range(1, 24));
         send(t, id, 32'($urandom_range(1, 20)), 64'($urandom_range(1, 10)), lat);
         checks++;
         if (lat !== 2) begin $display("FAIL random_latency op%0d: got %0d expected 2", n, lat); errors++; end
         for (int r = 1; r <= 4; r++) begin
            checks++;
            if (dut_rank(r) !== exp_rank(r)) begin
               $display("FAIL random op%0d type=%h rank%0d: got %h expected %h", n, t, r, dut_rank(r), exp_rank(r));
               errors++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_increasing();
      test_delete();
      test_execute();
      test_equal_price();
      test_full_drop();
      test_reset_mid();
      test_other_type();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bid_book_top4
`default_nettype wire
